// File: rtl/mem_arbiter_pkg.sv
// Shared widths, op encodings, MMIO addresses and arbiter state encoding
// for the memory arbiter slice.
package mem_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int INST_OP_WIDTH  = 4;
  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [XLEN-1:0] MMIO_IN  = 32'h0003_0000;
  localparam logic [XLEN-1:0] MMIO_OUT = 32'h0003_0004;

  typedef enum logic [INST_OP_WIDTH-1:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd3,
    OP_LHU = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } inst_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

  function automatic logic is_store(input logic [INST_OP_WIDTH-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mmio(input logic [XLEN-1:0] addr);
    return (addr == MMIO_IN) || (addr == MMIO_OUT);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetcher, LSB and engine handshake signals of the memory arbiter.
// master = arbiter view, slave = fetcher/LSB/engine view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                      fet_req;
  logic [XLEN-1:0]           fet_addr;
  logic                      fet_gnt;
  logic                      fet_done;
  logic [XLEN-1:0]           fet_inst;

  logic                      lsb_req;
  logic [INST_OP_WIDTH-1:0]  lsb_op;
  logic [XLEN-1:0]           lsb_addr;
  logic [XLEN-1:0]           lsb_wdata;
  logic [ROB_SIZE_WIDTH-1:0] lsb_id;
  logic                      lsb_gnt;
  logic                      lsb_done;
  logic [XLEN-1:0]           lsb_rdata;
  logic [ROB_SIZE_WIDTH-1:0] lsb_done_id;

  logic                      eng_valid;
  logic                      eng_ready;
  logic                      eng_is_inst;
  logic [INST_OP_WIDTH-1:0]  eng_op;
  logic [XLEN-1:0]           eng_addr;
  logic [XLEN-1:0]           eng_wdata;
  logic                      eng_resp_valid;
  logic [XLEN-1:0]           eng_resp_data;

  modport master (
    input  fet_req, fet_addr,
    output fet_gnt, fet_done, fet_inst,
    input  lsb_req, lsb_op, lsb_addr, lsb_wdata, lsb_id,
    output lsb_gnt, lsb_done, lsb_rdata, lsb_done_id,
    output eng_valid, eng_is_inst, eng_op, eng_addr, eng_wdata,
    input  eng_ready, eng_resp_valid, eng_resp_data
  );

  modport slave (
    output fet_req, fet_addr,
    input  fet_gnt, fet_done, fet_inst,
    output lsb_req, lsb_op, lsb_addr, lsb_wdata, lsb_id,
    input  lsb_gnt, lsb_done, lsb_rdata, lsb_done_id,
    input  eng_valid, eng_is_inst, eng_op, eng_addr, eng_wdata,
    output eng_ready, eng_resp_valid, eng_resp_data
  );
endinterface

// File: rtl/mem_arb_select.sv
// Combinational IDLE-state arbitration: request eligibility plus the
// starvation guard that forces a fetch after STARVE_LIMIT LSB wins.
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     flush,
  input  logic                     io_buffer_full,
  input  logic                     fet_req,
  input  logic                     lsb_req,
  input  logic [INST_OP_WIDTH-1:0] lsb_op,
  input  logic [XLEN-1:0]          lsb_addr,
  input  logic [3:0]               starve_cnt,
  output logic                     pick_lsb,
  output logic                     pick_fet
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic lsb_elig;
  logic fet_elig;

  // Stores survive a flush; loads and fetches on the wrong path do not.
  always_comb begin
    lsb_elig = lsb_req
             && !(is_mmio(lsb_addr) && io_buffer_full)
             && !(flush && !is_store(lsb_op));
    fet_elig = fet_req && !flush;
    pick_lsb = lsb_elig && (!fet_elig || (starve_cnt < LIMIT));
    pick_fet = fet_elig && !pick_lsb;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory engine between fetcher and LSB: one latched request at
// a time, valid/ready issue, response routed back to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  input  logic          io_buffer_full,
  output logic          busy,
  mem_arbiter_if.master bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e                state_q, state_d;
  logic [3:0]                starve_q, starve_d;
  logic                      own_inst_q, own_inst_d;
  logic [INST_OP_WIDTH-1:0]  op_q, op_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  logic [ROB_SIZE_WIDTH-1:0] id_q, id_d;
  logic                      fet_done_q, fet_done_d;
  logic [XLEN-1:0]           fet_inst_q, fet_inst_d;
  logic                      lsb_done_q, lsb_done_d;
  logic [XLEN-1:0]           lsb_rdata_q, lsb_rdata_d;
  logic [ROB_SIZE_WIDTH-1:0] lsb_done_id_q, lsb_done_id_d;

  logic pick_lsb, pick_fet;
  logic fet_gnt_c, lsb_gnt_c;
  logic cancel;

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .fet_req        (bus.fet_req),
    .lsb_req        (bus.lsb_req),
    .lsb_op         (bus.lsb_op),
    .lsb_addr       (bus.lsb_addr),
    .starve_cnt     (starve_q),
    .pick_lsb       (pick_lsb),
    .pick_fet       (pick_fet)
  );

  assign cancel = flush && (own_inst_q || !is_store(op_q));

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    starve_d      = starve_q;
    own_inst_d    = own_inst_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    id_d          = id_q;
    fet_done_d    = fet_done_q;
    fet_inst_d    = fet_inst_q;
    lsb_done_d    = lsb_done_q;
    lsb_rdata_d   = lsb_rdata_q;
    lsb_done_id_d = lsb_done_id_q;
    fet_gnt_c     = 1'b0;
    lsb_gnt_c     = 1'b0;

    if (rdy) begin
      fet_done_d = 1'b0;
      lsb_done_d = 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_lsb) begin
            lsb_gnt_c  = 1'b1;
            own_inst_d = 1'b0;
            op_d       = bus.lsb_op;
            addr_d     = bus.lsb_addr;
            wdata_d    = bus.lsb_wdata;
            id_d       = bus.lsb_id;
            starve_d   = !bus.fet_req ? 4'd0
                       : (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
            state_d    = ARB_ISSUE;
          end else if (pick_fet) begin
            fet_gnt_c  = 1'b1;
            own_inst_d = 1'b1;
            op_d       = OP_LW;
            addr_d     = bus.fet_addr;
            wdata_d    = '0;
            starve_d   = 4'd0;
            state_d    = ARB_ISSUE;
          end
        end
        // A flush that lands on the accepting edge must still absorb the response.
        ARB_ISSUE: begin
          if (cancel)              state_d = bus.eng_ready ? ARB_DRAIN : ARB_IDLE;
          else if (bus.eng_ready)  state_d = ARB_WAIT;
        end
        ARB_WAIT: begin
          if (bus.eng_resp_valid) begin
            state_d = ARB_IDLE;
            if (!cancel) begin
              if (own_inst_q) begin
                fet_done_d = 1'b1;
                fet_inst_d = bus.eng_resp_data;
              end else begin
                lsb_done_d    = 1'b1;
                lsb_rdata_d   = is_store(op_q) ? '0 : bus.eng_resp_data;
                lsb_done_id_d = id_q;
              end
            end
          end else if (cancel) begin
            state_d = ARB_DRAIN;
          end
        end
        ARB_DRAIN: if (bus.eng_resp_valid) state_d = ARB_IDLE;
        default:   state_d = ARB_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      starve_q      <= '0;
      own_inst_q    <= 1'b0;
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      id_q          <= '0;
      fet_done_q    <= 1'b0;
      fet_inst_q    <= '0;
      lsb_done_q    <= 1'b0;
      lsb_rdata_q   <= '0;
      lsb_done_id_q <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      own_inst_q    <= own_inst_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      id_q          <= id_d;
      fet_done_q    <= fet_done_d;
      fet_inst_q    <= fet_inst_d;
      lsb_done_q    <= lsb_done_d;
      lsb_rdata_q   <= lsb_rdata_d;
      lsb_done_id_q <= lsb_done_id_d;
    end
  end

  assign busy            = (state_q != ARB_IDLE);
  assign bus.fet_gnt     = fet_gnt_c;
  assign bus.lsb_gnt     = lsb_gnt_c;
  assign bus.fet_done    = fet_done_q;
  assign bus.fet_inst    = fet_inst_q;
  assign bus.lsb_done    = lsb_done_q;
  assign bus.lsb_rdata   = lsb_rdata_q;
  assign bus.lsb_done_id = lsb_done_id_q;
  assign bus.eng_valid   = (state_q == ARB_ISSUE);
  assign bus.eng_is_inst = own_inst_q;
  assign bus.eng_op      = op_q;
  assign bus.eng_addr    = addr_q;
  assign bus.eng_wdata   = wdata_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single word-level memory engine between the fetcher (instruction reads) and the LSB (loads/stores, including MMIO at 0x30000/0x30004). It latches one request at a time, issues it to the engine with a valid/ready handshake, then routes the response back to its owner. The fetcher cannot be starved, in-flight loads and fetches are cancelled on flush, and stores are never cancelled.

Parameters:
STARVE_LIMIT, 4, max consecutive LSB grants while fet_req is pending before fetch is forced (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 freezes all state and outputs
flush  in  1  pipeline flush (mispredict)
io_buffer_full  in  1  UART output buffer full
fet_req  in  1  fetch request, held until fet_gnt
fet_addr  in  XLEN  fetch PC
fet_gnt  out  1  one-cycle grant pulse
fet_done  out  1  one-cycle response pulse
fet_inst  out  XLEN  instruction, valid with fet_done
lsb_req  in  1  LSB request, held until lsb_gnt
lsb_op  in  INST_OP_WIDTH  LB/LH/LW/LBU/LHU/SB/SH/SW
lsb_addr  in  XLEN  byte address
lsb_wdata  in  XLEN  store data
lsb_id  in  ROB_SIZE_WIDTH  ROB tag
lsb_gnt  out  1  one-cycle grant pulse
lsb_done  out  1  one-cycle completion pulse (loads and stores)
lsb_rdata  out  XLEN  load result, 0 for stores
lsb_done_id  out  ROB_SIZE_WIDTH  tag of completed op
eng_valid  out  1  request to engine
eng_ready  in  1  engine accepts when eng_valid&eng_ready
eng_is_inst  out  1  1 = instruction fetch
eng_op  out  INST_OP_WIDTH  op (LW for fetch)
eng_addr  out  XLEN  address
eng_wdata  out  XLEN  store data
eng_resp_valid  in  1  engine completion pulse
eng_resp_data  in  XLEN  engine read data
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, starve_cnt=0, all outputs 0.
- rdy=0: nothing changes.
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE; DRAIN is used for cancelled requests.
- IDLE arbitration:
  - LSB is eligible if lsb_req, unless lsb_addr is MMIO and io_buffer_full.
  - Loads are ineligible while flush=1; stores stay eligible. Fetch is ineligible while flush=1.
  - LSB wins if eligible and (!fet_req || starve_cnt<STARVE_LIMIT); otherwise fetch wins if fet_req.
- Grant cycle: registers owner, op, addr, wdata and id; pulses the matching gnt; moves to ISSUE. eng_valid=1 from the next cycle.
- ISSUE: hold eng_* stable until eng_valid&eng_ready at a posedge, then go to WAIT with eng_valid=0.
- WAIT: on eng_resp_valid, pulse fet_done or lsb_done for one cycle.
  - fet_inst or lsb_rdata is set from eng_resp_data (lsb_rdata=0 for stores); lsb_done_id is set to the latched id.
  - Return to IDLE. Next grant no earlier than the following cycle (one bubble).
- Flush with a load/fetch owner:
  - In ISSUE before handshake: drop eng_valid, go to IDLE, no done.
  - In the handshake cycle or in WAIT: go to DRAIN. DRAIN swallows eng_resp_valid with no done, then goes to IDLE.
- Flush with a store owner: no effect; the store completes with lsb_done.
- starve_cnt:
  - On an LSB grant with fet_req=1: +1, saturating at STARVE_LIMIT.
  - On a fetch grant, or an LSB grant with fet_req=0: cleared to 0.
- Simultaneous eng_resp_valid and flush in WAIT: a store completes; a load/fetch is dropped and the FSM goes to IDLE.
- eng_resp_valid outside WAIT/DRAIN is ignored.
- rst mid-transaction: immediate return to reset values. The engine is reset by the same rst.

Decomposition:
- Shared package/global_params: XLEN, INST_OP_WIDTH, ROB_SIZE_WIDTH, op encodings (SB/SH/SW/LW...), MMIO_IN/OUT addresses, and the ARB_IDLE/ISSUE/WAIT/DRAIN state encodings.
- Sub-module mem_arb_select (combinational eligibility plus starvation priority) is natural; everything else stays in mem_arbiter.

Test Plan:
- Fetch only: fet_req, addr 0x100; engine ready at cycle 2, resp 0x00000013 at cycle 5 -> fet_gnt at cycle 0, eng_valid cycles 1-2, fet_done with fet_inst=0x00000013 one cycle after resp.
- Contention: fet_req and lsb_req held permanently, STARVE_LIMIT=4 -> exactly 4 LSB grants, then 1 fetch grant, then the pattern repeats.
- Flush in WAIT of an LW (id 5) -> DRAIN; resp 0xDEADBEEF swallowed; no lsb_done; busy drops after resp.
- Flush in WAIT of an SW to 0x2000 -> lsb_done with id intact and lsb_rdata=0; a same-cycle fetch request is not granted.
- MMIO store to 0x30000 with io_buffer_full=1 and fet_req=1 -> fetch is granted; the store is granted the cycle after io_buffer_full=0 once IDLE.
- rdy=0 for 3 cycles during ISSUE with eng_ready=1 -> no state change; handshake completes on the first rdy=1 edge.
